seq_divider: RTL



---
 rtl/seq_divider_pkg.sv | 27 ++
 rtl/seq_divider_if.sv | 49 ++++
 rtl/seq_divider_div_step.sv | 40 ++++
 rtl/seq_divider.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider_pkg
//  Description : Shared types and constants for the sequential divider:
//                FSM state encoding, default operand width and a helper
//                that sizes the iteration counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_divider_pkg;

    // Default operand/result width
    localparam int DIV_WIDTH = 32;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // The counter must hold the value WIDTH itself, hence the extra bit
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage : seq_divider_pkg
`default_nettype wire

// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider_if
//  Description : Operand / result handshake bundle of the sequential
//                divider. The master side issues operands and consumes
//                results; the slave side is the divider itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid,
        output dividend,
        output divisor,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  in_valid,
        input  dividend,
        input  divisor,
        input  out_ready,
        output in_ready,
        output out_valid,
        output quotient,
        output remainder,
        output div_by_zero
    );

endinterface : seq_divider_if
`default_nettype wire

// File: rtl/seq_divider_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One restoring-division iteration. Shifts the next dividend
//                bit into the partial remainder, performs a WIDTH+1-bit trial
//                subtraction of the divisor and either keeps the difference
//                (quotient bit 1) or restores the shifted value (bit 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] i_rem,
    input  wire logic             i_dq_msb,
    input  wire logic [WIDTH-1:0] i_divisor,
    output logic      [WIDTH-1:0] o_rem,
    output logic                  o_q_bit
);

    // The partial remainder is always below the divisor, but it may still
    // have its MSB set, so the shifted value genuinely needs WIDTH+1 bits.
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    // Trial subtraction; the top bit of the difference is the borrow
    always_comb begin
        w_shifted = {i_rem, i_dq_msb};
        w_trial   = w_shifted - {1'b0, i_divisor};
        o_q_bit   = ~w_trial[WIDTH];
        // Either result fits in WIDTH bits: a kept difference is below the
        // divisor, a restored value was below the divisor as well.
        if (w_trial[WIDTH]) begin
            o_rem = w_shifted[WIDTH-1:0];
        end else begin
            o_rem = w_trial[WIDTH-1:0];
        end
    end

endmodule : div_step
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Iterative unsigned radix-2 restoring divider. Accepts a
//                dividend/divisor pair through a valid/ready handshake,
//                runs WIDTH trial-subtraction iterations and presents the
//                quotient and remainder through a second valid/ready
//                handshake. One operation in flight at a time.
//                Optional macro SEQ_DIVIDER_ZERO_CHECK_EN: detect a zero
//                divisor on accept, skip the iterations and flag
//                div_by_zero. Without it div_by_zero is tied low and a zero
//                divisor runs the normal iterations (same result values).
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  wire logic     clk,
    input  wire logic     rst,
    seq_divider_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q,     state_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [WIDTH-1:0] dq_q,        dq_d;       // dividend in, quotient out
    logic [WIDTH-1:0] rem_q,       rem_d;      // partial remainder
    logic [WIDTH-1:0] dvs_q,       dvs_d;      // latched divisor
    logic [WIDTH-1:0] quo_q,       quo_d;      // presented quotient
    logic [WIDTH-1:0] rmd_q,       rmd_d;      // presented remainder
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
    logic             dbz_q,       dbz_d;
`endif

    logic [WIDTH-1:0] w_rem_next;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_dq_next;

    div_step #(
        .WIDTH     (WIDTH)
    ) u_div_step (
        .i_rem     (rem_q),
        .i_dq_msb  (dq_q[WIDTH-1]),
        .i_divisor (dvs_q),
        .o_rem     (w_rem_next),
        .o_q_bit   (w_q_bit)
    );

    assign w_dq_next = {dq_q[WIDTH-2:0], w_q_bit};

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dq_d    = dq_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
        dbz_d   = dbz_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    dq_d  = bus.dividend;
                    dvs_d = bus.divisor;
                    rem_d = '0;
                    cnt_d = CW'(WIDTH);
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
                    // Zero divisor: the iterations would yield all ones and
                    // the dividend anyway, so publish that directly.
                    if (bus.divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rmd_d   = bus.dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
`else
                    state_d = BUSY;
`endif
                end
            end

            BUSY: begin
                rem_d = w_rem_next;
                dq_d  = w_dq_next;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
                // Final iteration: results are copied into the output
                // registers only now, so no partial value is ever visible.
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    quo_d   = w_dq_next;
                    rmd_d   = w_rem_next;
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
                    dbz_d   = 1'b0;
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dq_q        <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            rmd_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
            dbz_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dq_q        <= dq_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            quo_q       <= quo_d;
            rmd_q       <= rmd_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
            dbz_q       <= dbz_d;
`endif
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
    assign bus.div_by_zero = dbz_q;
`else
    assign bus.div_by_zero = 1'b0;
`endif

endmodule : seq_divider
`default_nettype wire
